// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode pipeline register.
// Registers each fetched word with its address and folds an opcode word plus
// its trailing immediate word into one decode packet. It also applies hazard
// stalls and branch flushes, and drives the fetch PC enable.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_OP   | next accepted word is classified as an opcode
// S_IMM  | opcode word held in pend_*, next accepted word is its immediate
module if_id_buffer #(
    parameter int                 INSTR_W   = 16,
    parameter int                 PC_W      = 32,
    parameter logic [2:0]         IMM_CLASS = 3'b110,
    parameter logic [INSTR_W-1:0] NOP       = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [PC_W-1:0]    if_pc,
    input  logic               if_valid,
    input  logic               stall,
    input  logic               flush,
    output logic               fetch_en,
    output logic [INSTR_W-1:0] id_instr,
    output logic [INSTR_W-1:0] id_imm,
    output logic [PC_W-1:0]    id_pc,
    output logic               id_has_imm,
    output logic               id_valid
);

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [INSTR_W-1:0] pend_instr, pend_instr_nxt;
    logic [PC_W-1:0]    pend_pc, pend_pc_nxt;

    logic [INSTR_W-1:0] id_instr_nxt;
    logic [INSTR_W-1:0] id_imm_nxt;
    logic [PC_W-1:0]    id_pc_nxt;
    logic               id_has_imm_nxt;
    logic               id_valid_nxt;

    logic word_acc;
    logic is_imm_class;

    // The fetch PC only advances while decode is not being held.
    always_comb fetch_en = !stall;

    // A word is consumed only when it is valid and neither stall nor flush is up.
    always_comb begin
        word_acc     = if_valid && !stall && !flush;
        is_imm_class = (if_instr[INSTR_W-1 -: 3] == IMM_CLASS);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_OP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next decode packet; flush beats stall, stall beats a gap.
    always_comb begin
        state_nxt      = state;
        pend_instr_nxt = pend_instr;
        pend_pc_nxt    = pend_pc;
        id_instr_nxt   = id_instr;
        id_imm_nxt     = id_imm;
        id_pc_nxt      = id_pc;
        id_has_imm_nxt = id_has_imm;
        id_valid_nxt   = id_valid;

        if (flush) begin
            state_nxt      = S_OP;
            pend_instr_nxt = '0;
            pend_pc_nxt    = '0;
            id_instr_nxt   = NOP;
            id_imm_nxt     = '0;
            id_has_imm_nxt = 1'b0;
            id_valid_nxt   = 1'b0;
        end else if (stall) begin
            state_nxt = state;
        end else if (!word_acc) begin
            // Gap in fetch: bubble, id_pc keeps the last packet's address.
            id_instr_nxt   = NOP;
            id_imm_nxt     = '0;
            id_has_imm_nxt = 1'b0;
            id_valid_nxt   = 1'b0;
        end else begin
            unique case (state)
                S_OP: begin
                    if (is_imm_class) begin
                        // Park the opcode; decode sees one bubble meanwhile.
                        pend_instr_nxt = if_instr;
                        pend_pc_nxt    = if_pc;
                        id_instr_nxt   = NOP;
                        id_imm_nxt     = '0;
                        id_has_imm_nxt = 1'b0;
                        id_valid_nxt   = 1'b0;
                        state_nxt      = S_IMM;
                    end else begin
                        id_instr_nxt   = if_instr;
                        id_imm_nxt     = '0;
                        id_pc_nxt      = if_pc;
                        id_has_imm_nxt = 1'b0;
                        id_valid_nxt   = 1'b1;
                    end
                end
                S_IMM: begin
                    // The immediate is raw data; its top bits are not decoded.
                    id_instr_nxt   = pend_instr;
                    id_imm_nxt     = if_instr;
                    id_pc_nxt      = pend_pc;
                    id_has_imm_nxt = 1'b1;
                    id_valid_nxt   = 1'b1;
                    state_nxt      = S_OP;
                end
                default: begin
                    state_nxt = S_OP;
                end
            endcase
        end
    end

    // Pending opcode registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_instr <= '0;
            pend_pc    <= '0;
        end else begin
            pend_instr <= pend_instr_nxt;
            pend_pc    <= pend_pc_nxt;
        end
    end

    // Decode packet registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_instr   <= NOP;
            id_imm     <= '0;
            id_pc      <= '0;
            id_has_imm <= 1'b0;
            id_valid   <= 1'b0;
        end else begin
            id_instr   <= id_instr_nxt;
            id_imm     <= id_imm_nxt;
            id_pc      <= id_pc_nxt;
            id_has_imm <= id_has_imm_nxt;
            id_valid   <= id_valid_nxt;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: a driver applies directed then random fetch traffic
// and pushes the expected decode packet; a monitor pops and compares it after
// every rising edge.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        stall;
    logic        flush;
    logic        fetch_en;
    logic [15:0] id_instr;
    logic [15:0] id_imm;
    logic [31:0] id_pc;
    logic        id_has_imm;
    logic        id_valid;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [31:0] pc;
        logic        has_imm;
        logic        valid;
    } pkt_t;

    pkt_t exp_q[$];

    // Reference model: last packet shown to decode and an optional held opcode.
    pkt_t        m_out;
    bit          m_have_op;
    logic [15:0] m_op_instr;
    logic [31:0] m_op_pc;

    if_id_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .stall      (stall),
        .flush      (flush),
        .fetch_en   (fetch_en),
        .id_instr   (id_instr),
        .id_imm     (id_imm),
        .id_pc      (id_pc),
        .id_has_imm (id_has_imm),
        .id_valid   (id_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out     = '{instr: 16'h0000, imm: 16'h0000, pc: 32'h0, has_imm: 1'b0, valid: 1'b0};
        m_have_op = 1'b0;
        m_op_instr = '0;
        m_op_pc   = '0;
    endtask

    function automatic pkt_t bubble(input pkt_t prev);
        pkt_t b;
        b = '{instr: 16'h0000, imm: 16'h0000, pc: prev.pc, has_imm: 1'b0, valid: 1'b0};
        return b;
    endfunction

    task automatic model_step(input bit v, input logic [15:0] w, input logic [31:0] pc,
                              input bit st, input bit fl);
        if (fl) begin
            m_out     = bubble(m_out);
            m_have_op = 1'b0;
        end else if (st) begin
            m_out = m_out;
        end else if (!v) begin
            m_out = bubble(m_out);
        end else if (m_have_op) begin
            m_out     = '{instr: m_op_instr, imm: w, pc: m_op_pc, has_imm: 1'b1, valid: 1'b1};
            m_have_op = 1'b0;
        end else if (w[15:13] == 3'b110) begin
            m_have_op  = 1'b1;
            m_op_instr = w;
            m_op_pc    = pc;
            m_out      = bubble(m_out);
        end else begin
            m_out = '{instr: w, imm: 16'h0000, pc: pc, has_imm: 1'b0, valid: 1'b1};
        end
    endtask

    // Drive one cycle from the falling edge; expectation is queued for the monitor.
    task automatic cycle(input bit v, input logic [15:0] w, input logic [31:0] pc,
                         input bit st, input bit fl);
        if_valid = v;
        if_instr = w;
        if_pc    = pc;
        stall    = st;
        flush    = fl;
        #1;
        chk("fetch_en", {31'b0, fetch_en}, {31'b0, !st});
        model_step(v, w, pc, st, fl);
        exp_q.push_back(m_out);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".id_instr"},   {16'b0, id_instr}, 32'h0);
        chk({tag, ".id_imm"},     {16'b0, id_imm}, 32'h0);
        chk({tag, ".id_pc"},      id_pc, 32'h0);
        chk({tag, ".id_has_imm"}, {31'b0, id_has_imm}, 32'h0);
        chk({tag, ".id_valid"},   {31'b0, id_valid}, 32'h0);
    endtask

    // Monitor: the DUT presents a packet after every edge; compare against the queue head.
    initial begin
        pkt_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("id_instr",   {16'b0, id_instr}, {16'b0, e.instr});
                chk("id_imm",     {16'b0, id_imm}, {16'b0, e.imm});
                chk("id_pc",      id_pc, e.pc);
                chk("id_has_imm", {31'b0, id_has_imm}, {31'b0, e.has_imm});
                chk("id_valid",   {31'b0, id_valid}, {31'b0, e.valid});
            end
        end
    end

    initial begin
        logic [31:0] pc_ctr;
        bit          v, st, fl;
        logic [15:0] w;

        rst = 1'b1;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc = '0;
        stall = 1'b1;
        flush = 1'b0;
        model_reset();
        #3;
        chk("rst.fetch_en_stalled", {31'b0, fetch_en}, 32'h0);
        stall = 1'b0;
        #1;
        chk("rst.fetch_en_free", {31'b0, fetch_en}, 32'h1);
        @(negedge clk);
        chk_reset_outputs("rst0");
        rst = 1'b0;

        // Asynchronous reset in the middle of a cycle while a packet is valid.
        cycle(1, 16'h5555, 32'h10, 0, 0);
        chk("pre_rst.id_valid", {31'b0, id_valid}, 32'h1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_mid");
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);

        cycle(1, 16'h1234, 32'h20, 0, 0);
        // Stall for three cycles, then continue.
        cycle(1, 16'h9999, 32'h21, 1, 0);
        cycle(1, 16'h9999, 32'h21, 1, 0);
        cycle(1, 16'h9999, 32'h21, 1, 0);
        cycle(1, 16'h2222, 32'h21, 0, 0);
        // Two-word instruction.
        cycle(1, 16'hC005, 32'h21, 0, 0);
        cycle(1, 16'hBEEF, 32'h22, 0, 0);
        // Stall while the opcode is pending; immediate with class bits of 0.
        cycle(1, 16'hC001, 32'h30, 0, 0);
        cycle(1, 16'h00AA, 32'h31, 1, 0);
        cycle(1, 16'h00AA, 32'h31, 1, 0);
        cycle(1, 16'h00AA, 32'h31, 0, 0);
        // Immediate word that itself carries the opcode class bits.
        cycle(1, 16'hC003, 32'h32, 0, 0);
        cycle(1, 16'hDEAD, 32'h33, 0, 0);
        // Flush with stall and a valid word while pending.
        cycle(1, 16'hC001, 32'h34, 0, 0);
        cycle(1, 16'h7777, 32'h35, 1, 1);
        cycle(1, 16'hC002, 32'h40, 0, 0);
        cycle(0, 16'h0000, 32'h41, 0, 0);
        cycle(1, 16'h0042, 32'h41, 0, 0);
        // Gaps in S_OP.
        cycle(1, 16'h3333, 32'h42, 0, 0);
        cycle(0, 16'hFFFF, 32'h43, 0, 0);
        cycle(0, 16'hFFFF, 32'h43, 0, 0);
        cycle(1, 16'h4444, 32'h43, 0, 0);

        // Random traffic with word addresses advancing on each accepted word.
        pc_ctr = 32'h100;
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 9) < 8);
            st = ($urandom_range(0, 9) < 2);
            fl = ($urandom_range(0, 24) < 2);
            w  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:13] = 3'b110;
            cycle(v, w, pc_ctr, st, fl);
            if (v && !st && !fl) pc_ctr = pc_ctr + 1;
        end

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Pipeline buffer between the fetch stage and the decode stage. It registers each fetched 16-bit word with its 32-bit word address and assembles two-word instructions (opcode word followed by a 16-bit immediate word) into one decode packet. It also applies hazard-unit stalls and branch flushes, and it drives the fetch-stage PC enable.

## Interface
Parameters:
- INSTR_W, 16, instruction/immediate word width
- PC_W, 32, program-counter width (word address)
- IMM_CLASS, 3'b110, value of instr[15:13] that marks an opcode word followed by an immediate word
- NOP, 16'h0000, encoding inserted on bubble/flush

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_instr  in  INSTR_W  word fetched this cycle
- if_pc  in  PC_W  word address of if_instr
- if_valid  in  1  if_instr/if_pc are meaningful this cycle
- stall  in  1  hazard unit: hold decode packet and freeze fetch
- flush  in  1  branch resolved taken: discard buffered/pending words
- fetch_en  out  1  PC enable for the fetch stage; equals !stall (combinational)
- id_instr  out  INSTR_W  opcode word presented to decode
- id_imm  out  INSTR_W  immediate word (valid when id_has_imm)
- id_pc  out  PC_W  address of the opcode word
- id_has_imm  out  1  packet is a two-word instruction
- id_valid  out  1  decode packet is a real instruction (0 = bubble)

## Operation
- Two-state FSM: S_OP (expecting opcode word) and S_IMM (opcode word latched in pending regs, expecting its immediate).
- Word accepted = if_valid & !stall & !flush.
- S_OP, word accepted, if_instr[15:13] != IMM_CLASS: id_instr<=if_instr, id_pc<=if_pc, id_imm<=0, id_has_imm<=0, id_valid<=1; stay in S_OP.
- S_OP, word accepted, if_instr[15:13] == IMM_CLASS: pend_instr<=if_instr, pend_pc<=if_pc; emit bubble (id_instr<=NOP, id_valid<=0, id_has_imm<=0); go to S_IMM.
- S_IMM, word accepted: id_instr<=pend_instr, id_imm<=if_instr (immediate word, not decoded for class), id_pc<=pend_pc, id_has_imm<=1, id_valid<=1; go to S_OP.
- Not accepted because if_valid=0 (and no stall/flush): emit bubble; state and pending regs hold.
- stall=1, flush=0: all output regs, pending regs and state hold; fetch_en=0.
- flush=1: overrides stall and if_valid. id_instr<=NOP, id_imm<=0, id_has_imm<=0, id_valid<=0, pending regs cleared, state<=S_OP. The word on if_instr that cycle is dropped.
- Bubble outputs: id_pc holds its previous value; id_imm<=0.

## Timing
- Reset (asynchronous): state=S_OP, id_instr=NOP, id_imm=0, id_pc=0, id_has_imm=0, id_valid=0, pend_instr=0, pend_pc=0. fetch_en follows !stall even during reset.
- Single-word latency: 1 cycle. A word accepted at edge N is on id_* after edge N.
- Two-word latency: the packet appears after the edge that accepts the immediate word. The opcode-accept edge produces exactly one bubble cycle.
- Stall extending across S_IMM keeps the pending opcode. Assembly resumes on the first accepted word after stall drops.
- Flush while in S_IMM drops the pending opcode. The next accepted word is classified as an opcode.
- A flush in the same cycle as a stall or an if_valid word: flush wins.
- Reset asserted mid-operation (any state) returns all outputs to reset values immediately, without waiting for a clock edge.
- Each accepted word's if_pc is the address of that word, incrementing by 1 per fetched word. id_pc is not incremented inside this block.

## Test plan
- Reset: assert rst mid-cycle with id_valid=1 -> all outputs to reset values before the next edge; after release with if_instr=16'h1234, if_pc=32'h20 -> next cycle id_instr=16'h1234, id_pc=32'h20, id_valid=1, id_has_imm=0.
- Two-word: words 16'hC005 @0x21 then 16'hBEEF @0x22 -> one bubble cycle, then id_instr=16'hC005, id_imm=16'hBEEF, id_pc=32'h21, id_has_imm=1, id_valid=1.
- Stall: stall=1 for 3 cycles while id_instr=16'h1234 -> fetch_en=0 and id_* held all 3 cycles; stall=0 -> next word 16'h2222 @0x21 appears one cycle later.
- Stall in S_IMM: 16'hC001 @0x30, stall 2 cycles, then 16'h00AA @0x31 -> packet id_instr=16'hC001, id_imm=16'h00AA, id_pc=32'h30.
- Flush in S_IMM: 16'hC001 accepted, then flush=1 with stall=1 and if_instr=16'h7777 -> id_valid=0, state S_OP; next word 16'hC002 @0x40 is treated as an opcode (bubble, then waits for its immediate).
- Gaps: if_valid=0 for 2 cycles in S_OP -> id_valid=0, id_instr=NOP; id_pc unchanged.
